mem_byte_seq: RTL and testbench

Requester-side sequencer for the MEM stage, at the opposite end of the byte-wide request/grant interface served by the memory controller. Accepts one load/store (LB/LH/LW/LBU/LHU/SB/SH/SW) from the MEM stage and splits it into 1, 2 or 4 single-byte RAM accesses. For loads, it assembles the returned bytes little-endian and sign/zero-extends the result. Holds a stall request to the pipeline until the access completes.

---
 rtl/mem_byte_seq_pkg.sv | 38 +++
 rtl/mem_byte_seq_load_ext.sv | 21 ++
 rtl/mem_byte_seq.sv | 115 +++++++++++
 tb/tb_mem_byte_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_byte_seq_pkg.sv
// Shared constants and types for the MEM-stage byte sequencer:
// reset level, request/grant codes, funct3 codes and FSM state encoding.
package mem_byte_seq_pkg;

  localparam logic RstEnable = 1'b1;

  localparam logic [1:0] MemNone  = 2'b00;
  localparam logic [1:0] MemLoad  = 2'b01;
  localparam logic [1:0] MemStore = 2'b10;

  localparam logic [1:0] GrantIF  = 2'b01;
  localparam logic [1:0] GrantMem = 2'b10;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } seq_state_e;

  // Size lives in funct3[1:0]; the unsigned bit does not change byte count.
  function automatic logic [2:0] byte_count(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_seq_load_ext.sv
// Combinational size and sign/zero extension of an assembled load word.
module mem_byte_seq_load_ext
  import mem_byte_seq_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (funct3)
      LB:      ext = {{24{raw[7]}}, raw[7:0]};
      LH:      ext = {{16{raw[15]}}, raw[15:0]};
      LBU:     ext = {24'd0, raw[7:0]};
      LHU:     ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_byte_seq.sv
// Splits one MEM-stage load/store into single-byte RAM accesses over the
// request/grant interface, assembling and extending load data.
//
// state  | meaning
// IDLE   | waiting for start; latches the access when it arrives
// ACCESS | issuing bytes on grant=10, capturing returned load bytes
// DONE   | one-cycle completion pulse, rdata valid
module mem_byte_seq
  import mem_byte_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [1:0]  mem_request,
  output logic [31:0] mem_addr,
  output logic [7:0]  byte_o,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  grant,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata
);

  seq_state_e  state_q, state_d;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, asm_q, asm_next, rdata_q, ext_val;
  logic [2:0]  k_q, r_q, n;
  logic        pend_q;
  logic        issue, capture, last_issue, last_capture;

  assign n            = byte_count(funct3_q);
  assign issue        = (state_q == ST_ACCESS) && (k_q < n) && (grant == GrantMem);
  assign capture      = (state_q == ST_ACCESS) && pend_q;
  assign last_issue   = issue && (k_q == n - 3'd1);
  assign last_capture = capture && (r_q == n - 3'd1);

  // The final byte is merged before extension so rdata is valid in DONE.
  always_comb begin
    asm_next = asm_q;
    asm_next[{r_q[1:0], 3'b000} +: 8] = byte_i;
  end

  mem_byte_seq_load_ext u_load_ext (
    .funct3 (funct3_q),
    .raw    (asm_next),
    .ext    (ext_val)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) state_q <= ST_IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ACCESS;
      ST_ACCESS: if (is_store_q ? last_issue : last_capture) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_request = MemNone;
    mem_addr    = 32'd0;
    byte_o      = 8'd0;
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);
    if (state_q == ST_ACCESS && k_q < n) begin
      mem_request = is_store_q ? MemStore : MemLoad;
      mem_addr    = addr_q + {29'd0, k_q};
      byte_o      = is_store_q ? wdata_q[{k_q[1:0], 3'b000} +: 8] : 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      asm_q      <= 32'd0;
      rdata_q    <= 32'd0;
      k_q        <= 3'd0;
      r_q        <= 3'd0;
      pend_q     <= 1'b0;
    end else begin
      pend_q <= issue && !is_store_q;
      if (state_q == ST_IDLE && start) begin
        is_store_q <= is_store;
        funct3_q   <= funct3;
        addr_q     <= addr;
        wdata_q    <= wdata;
        asm_q      <= 32'd0;
        k_q        <= 3'd0;
        r_q        <= 3'd0;
      end
      if (issue) k_q <= k_q + 3'd1;
      if (capture) begin
        asm_q <= asm_next;
        r_q   <= r_q + 3'd1;
      end
      if (last_capture && !is_store_q) rdata_q <= ext_val;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_byte_seq.sv
// Self-checking bench for mem_byte_seq: a byte-RAM controller model plus a
// transaction-level reference for addresses, latency and load results.
module tb_mem_byte_seq;

  logic        clk = 1'b0;
  logic        rst, start, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [1:0]  mem_request;
  logic [31:0] mem_addr;
  logic [7:0]  byte_o, byte_i;
  logic [1:0]  grant;
  logic        busy, done;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  bit [7:0] phys[bit [31:0]];
  bit [7:0] expm[bit [31:0]];
  logic [31:0] exp_rdata = 32'd0;

  logic [1:0]  rsp_rq, rsp_g;
  logic [31:0] rsp_a;
  logic [7:0]  rsp_d;

  mem_byte_seq dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .mem_request(mem_request), .mem_addr(mem_addr),
    .byte_o(byte_o), .byte_i(byte_i), .grant(grant), .busy(busy), .done(done),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  function automatic bit [7:0] phys_rd(input bit [31:0] a);
    return phys.exists(a) ? phys[a] : 8'h00;
  endfunction

  function automatic bit [7:0] exp_rd(input bit [31:0] a);
    return expm.exists(a) ? expm[a] : 8'h00;
  endfunction

  // Memory controller: a granted request is served at the end of its cycle;
  // read data shows up on byte_i during the following cycle.
  always @(posedge clk) begin
    rsp_rq = mem_request;
    rsp_g  = grant;
    rsp_a  = mem_addr;
    rsp_d  = byte_o;
    #1;
    if (rsp_g == 2'b10 && rsp_rq == 2'b10) phys[rsp_a] = rsp_d;
    byte_i = (rsp_g == 2'b10 && rsp_rq == 2'b01) ? phys_rd(rsp_a) : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic seed(input bit [31:0] a, input bit [7:0] d);
    phys[a] = d;
    expm[a] = d;
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << (f3 & 3'd3);
  endfunction

  // Reference load result straight from the extension rules.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    longint v = 0;
    for (int i = 0; i < nbytes(f3); i++) v = v + (longint'(exp_rd(a + i)) << (8 * i));
    case (f3)
      3'b000:  v = ((v % 256) ^ 128) - 128;
      3'b001:  v = ((v % 65536) ^ 32768) - 32768;
      default: v = v;
    endcase
    return v[31:0];
  endfunction

  // mode 0: grant=10 always; 1: random grants; 2: grant=01 in cycles 2 and 3
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int mode, input bit poke);
    int n, granted, done_cyc, cyc, r;
    logic [1:0] g;
    n = nbytes(f3);
    @(posedge clk); #1;
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd; grant = 2'b10;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_req", 32'(mem_request), 32'd0);
    if (st) for (int i = 0; i < n; i++) expm[a + i] = 8'((wd >> (8 * i)) & 32'hFF);
    else exp_rdata = ref_load(f3, a);
    granted = 0; done_cyc = -1; cyc = 0;
    while (1) begin
      cyc++;
      @(posedge clk); #1;
      start = poke && (cyc == 2);
      r = $urandom_range(0, 3);
      case (mode)
        0:       g = 2'b10;
        1:       g = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b10;
        default: g = (cyc == 2 || cyc == 3) ? 2'b01 : 2'b10;
      endcase
      grant = g;
      @(negedge clk);
      chk("busy", 32'(busy), 32'd1);
      chk("done", 32'(done), 32'(cyc == done_cyc));
      if (granted < n) begin
        chk("req", 32'(mem_request), st ? 32'd2 : 32'd1);
        chk("addr", mem_addr, a + granted);
        chk("byte_o", 32'(byte_o), st ? ((wd >> (8 * granted)) & 32'hFF) : 32'd0);
      end else begin
        chk("req_idle", 32'(mem_request), 32'd0);
        chk("addr_idle", mem_addr, 32'd0);
      end
      if (cyc == done_cyc) begin
        chk("rdata", rdata, exp_rdata);
        break;
      end
      if (g == 2'b10 && granted < n) begin
        granted++;
        if (granted == n) done_cyc = cyc + (st ? 1 : 2);
      end
      if (cyc >= 200) begin
        chk("timeout_done", 32'(done), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; grant = 2'b10;
    @(negedge clk);
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_req", 32'(mem_request), 32'd0);
    chk("post_rdata", rdata, exp_rdata);
    if (st) for (int i = -1; i <= n; i++)
      chk("ram", 32'(phys_rd(a + i)), 32'(exp_rd(a + i)));
  endtask

  initial begin
    logic [31:0] wd;
    logic [2:0] f3;
    bit st;
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; grant = 2'b00; byte_i = 8'h00;

    seed(32'h100, 8'h78); seed(32'h101, 8'h56); seed(32'h102, 8'h34); seed(32'h103, 8'h12);
    seed(32'h20, 8'h80); seed(32'h30, 8'h00); seed(32'h31, 8'h80);
    for (int i = 0; i < 8; i++) seed(32'h40 + i, 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 8; i++) seed(32'h50 + i, 8'h5A);
    for (int i = 0; i < 80; i++) seed(32'h200 + i, 8'($urandom));
    for (int i = -4; i < 4; i++) seed(32'(i), 8'($urandom));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(mem_request), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_byte_o", 32'(byte_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(1'b0, 3'b010, 32'h100, 32'd0, 0, 1'b0);
    chk("lw_value", rdata, 32'h12345678);
    run_op(1'b0, 3'b000, 32'h20, 32'd0, 0, 1'b0);
    chk("lb_value", rdata, 32'hFFFFFF80);
    run_op(1'b0, 3'b100, 32'h20, 32'd0, 0, 1'b0);
    chk("lbu_value", rdata, 32'h00000080);
    run_op(1'b0, 3'b001, 32'h30, 32'd0, 0, 1'b0);
    chk("lh_value", rdata, 32'hFFFF8000);
    run_op(1'b1, 3'b001, 32'h40, 32'hAABBCCDD, 0, 1'b0);
    chk("sh_untouched", 32'(phys_rd(32'h42)), 32'h33);
    run_op(1'b0, 3'b010, 32'h100, 32'd0, 2, 1'b0);
    chk("lw_stall_value", rdata, 32'h12345678);

    // Reset in the second cycle of a store: two bytes land, the rest never do.
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h50; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0; grant = 2'b10;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", 32'(mem_request), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_byte_o", 32'(byte_o), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_quiet", 32'(mem_request), 32'd0);
    end
    chk("mid_rst_b0", 32'(phys_rd(32'h50)), 32'hEF);
    chk("mid_rst_b1", 32'(phys_rd(32'h51)), 32'hBE);
    chk("mid_rst_b2", 32'(phys_rd(32'h52)), 32'h5A);
    chk("mid_rst_b3", 32'(phys_rd(32'h53)), 32'h5A);
    expm[32'h50] = 8'hEF; expm[32'h51] = 8'hBE;
    exp_rdata = 32'd0;
    run_op(1'b1, 3'b010, 32'h50, 32'h01020304, 0, 1'b0);
    run_op(1'b0, 3'b010, 32'h50, 32'd0, 0, 1'b0);
    chk("after_rst_value", rdata, 32'h01020304);

    run_op(1'b0, 3'b010, 32'h100, 32'd0, 0, 1'b1);
    run_op(1'b1, 3'b000, 32'h44, 32'h000000A5, 0, 1'b1);
    run_op(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, 1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      st = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = st ? 3'b000 : 3'b100;
        default: f3 = st ? 3'b001 : 3'b101;
      endcase
      wd = $urandom;
      if ($urandom_range(0, 7) == 0) run_op(st, f3, 32'hFFFFFFFD + $urandom_range(0, 4), wd, 1, 1'($urandom_range(0, 1)));
      else run_op(st, f3, 32'h200 + $urandom_range(0, 70), wd, 1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
